// File: rtl/nabp_angle_sequencer.sv
// Angle sequencer for the double-banked filtered RAM: prefetches angles into the free bank and issues them to the consumer.
// Optional NABP_ANGLE_SEQ_STALL_CNT_EN adds a saturating stall_cycles counter output.
module nabp_angle_sequencer #(
  parameter int ANGLE_WIDTH = 9,
  parameter int ANGLE_MAX   = 180,
  parameter int ANGLE_STEP  = 1,
  parameter int COUNT_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   kick,
  input  logic [ANGLE_WIDTH-1:0] angle_start,
  input  logic [COUNT_WIDTH-1:0] angle_count,
  output logic                   busy,
  output logic                   done,
  output logic                   ld_req,
  output logic [ANGLE_WIDTH-1:0] ld_angle,
  output logic                   ld_bank,
  input  logic                   ld_done,
  output logic [ANGLE_WIDTH-1:0] fr_angle,
  output logic                   fr_bank,
  output logic                   fr_has_next_angle,
  input  logic                   fr_next_angle,
  output logic                   fr_next_angle_ack,
  output logic [2:0]             state_dbg
`ifdef NABP_ANGLE_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  // Handshakes: ld_req is held with ld_angle/ld_bank stable until the one-cycle
  // ld_done; fr_next_angle is held until the combinational fr_next_angle_ack,
  // and a transfer happens on every clock edge where request and ack are both high.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_WAIT_LD = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  logic [2:0]             state;
  logic                   wr_bank;
  logic                   rd_bank;
  logic [1:0]             bank_valid;
  logic [ANGLE_WIDTH-1:0] bank_angle [2];
  logic [COUNT_WIDTH-1:0] loads_left;
  logic [COUNT_WIDTH-1:0] issues_left;
  logic [ANGLE_WIDTH-1:0] load_angle;
  logic                   owned_valid;
  logic                   can_load;
  logic                   load_fin;
  logic                   last_issue;

  function automatic logic [ANGLE_WIDTH-1:0] angle_inc(input logic [ANGLE_WIDTH-1:0] cur);
    logic [ANGLE_WIDTH:0] sum;
    sum = {1'b0, cur} + (ANGLE_WIDTH+1)'(ANGLE_STEP);
    if (sum >= (ANGLE_WIDTH+1)'(ANGLE_MAX)) sum = sum - (ANGLE_WIDTH+1)'(ANGLE_MAX);
    return sum[ANGLE_WIDTH-1:0];
  endfunction

  // The loader may only fill a bank that is neither holding data nor owned by the consumer.
  assign can_load = (loads_left != '0) && !bank_valid[wr_bank] &&
                    !(owned_valid && (fr_bank == wr_bank));

  assign busy              = (state != S_IDLE);
  assign done              = (state == S_FINISH);
  assign ld_req            = ((state == S_LOAD) && can_load) || (state == S_WAIT_LD);
  assign ld_angle          = load_angle;
  assign ld_bank           = wr_bank;
  assign fr_has_next_angle = busy && (issues_left != '0);
  assign fr_next_angle_ack = busy && fr_next_angle && bank_valid[rd_bank] && (issues_left != '0);
  assign load_fin          = (state == S_WAIT_LD) && ld_done;
  assign last_issue        = fr_next_angle_ack && (issues_left == COUNT_WIDTH'(1));
  assign state_dbg         = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      bank_valid    <= 2'b00;
      bank_angle[0] <= '0;
      bank_angle[1] <= '0;
      loads_left    <= '0;
      issues_left   <= '0;
      load_angle    <= '0;
      owned_valid   <= 1'b0;
      fr_angle      <= '0;
      fr_bank       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (kick) begin
            load_angle  <= angle_start;
            loads_left  <= angle_count;
            issues_left <= angle_count;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            bank_valid  <= 2'b00;
            owned_valid <= 1'b0;
            state       <= (angle_count == '0) ? S_FINISH : S_LOAD;
          end
        end
        S_LOAD: begin
          if (loads_left == '0) state <= S_RUN;
          else if (can_load)    state <= S_WAIT_LD;
        end
        S_WAIT_LD: begin
          if (ld_done) state <= S_LOAD;
        end
        S_RUN: state <= S_RUN;
        S_FINISH: begin
          bank_valid  <= 2'b00;
          owned_valid <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Issue path: the release and the load-complete set never target the same bank.
      if (fr_next_angle_ack) begin
        fr_angle    <= bank_angle[rd_bank];
        fr_bank     <= rd_bank;
        owned_valid <= 1'b1;
        if (owned_valid) bank_valid[fr_bank] <= 1'b0;
        rd_bank     <= ~rd_bank;
        issues_left <= issues_left - COUNT_WIDTH'(1);
      end

      if (load_fin) begin
        bank_valid[wr_bank] <= 1'b1;
        bank_angle[wr_bank] <= load_angle;
        wr_bank             <= ~wr_bank;
        loads_left          <= loads_left - COUNT_WIDTH'(1);
        load_angle          <= angle_inc(load_angle);
      end

      if (last_issue) state <= S_FINISH;
    end
  end

`ifdef NABP_ANGLE_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if ((state == S_IDLE) && kick) begin
      stall_cycles <= '0;
    end else if (busy && fr_next_angle && !fr_next_angle_ack && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
